// File: rtl/pc_sequencer_if.sv
// Control-operation handshake between the execute stage and the PC sequencer.
interface pc_sequencer_if;
  logic        ctl_valid;
  logic        ctl_ready;
  logic [2:0]  ctl_op;
  logic [31:0] ctl_target;
  logic [7:0]  ctl_tt;

  // Execute stage offers operations.
  modport master (output ctl_valid, ctl_op, ctl_target, ctl_tt, input ctl_ready);
  // Sequencer accepts them when idle.
  modport slave  (input ctl_valid, ctl_op, ctl_target, ctl_tt, output ctl_ready);
endinterface

// File: rtl/pc_sequencer.sv
// PC/nPC control-transfer sequencer: turns one accepted control op into an
// ordered pair of single-action strobes for the PC pair, and handles traps.
module pc_sequencer (
  input  logic        clk,
  input  logic        rst,
  pc_sequencer_if.slave ctl,
  input  logic        et,
  input  logic [19:0] tbr_base,
  input  logic [31:0] pc_cur,
  input  logic [31:0] npc_cur,
  output logic        pc_wr,
  output logic [31:0] pc_in,
  output logic        npc_wr,
  output logic [31:0] npc_in,
  output logic        pcs_inc,
  output logic        trap_taken,
  output logic [7:0]  trap_tt,
  output logic [31:0] trap_pc,
  output logic [31:0] trap_npc,
  output logic        error_mode
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_STEP1 = 2'd1;
  localparam logic [1:0] ST_STEP2 = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  localparam logic [2:0] OP_SEQ   = 3'd0;
  localparam logic [2:0] OP_XFER  = 3'd1;
  localparam logic [2:0] OP_ANNUL = 3'd2;
  localparam logic [2:0] OP_SKIP  = 3'd3;
  localparam logic [2:0] OP_TRAP  = 3'd4;
  localparam logic [2:0] OP_LOAD  = 3'd5;

  logic [1:0]  state;
  logic [2:0]  op_q;
  logic [31:0] data_q;   // target for transfers/loads, trap vector for traps
  logic [2:0]  acc_op;
  logic [7:0]  acc_tt;
  logic [31:0] acc_vec;
  logic        accept;

  assign ctl.ctl_ready = (state == ST_IDLE);
  assign error_mode    = (state == ST_ERROR);
  assign accept        = ctl.ctl_valid && (state == ST_IDLE);

  // Normalise the offered op: reserved codes act as SEQ, misaligned targets trap.
  always_comb begin
    acc_op = ctl.ctl_op;
    acc_tt = ctl.ctl_tt;
    if (ctl.ctl_op > OP_LOAD) acc_op = OP_SEQ;
    if ((acc_op == OP_XFER || acc_op == OP_ANNUL || acc_op == OP_LOAD) &&
        (ctl.ctl_target[1:0] != 2'b00)) begin
      acc_op = OP_TRAP;
      acc_tt = 8'h07;
    end
    acc_vec = {tbr_base, acc_tt, 4'b0000};
  end

  // Sequencer state, latched op/data and trap capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_q       <= OP_SEQ;
      data_q     <= '0;
      trap_taken <= 1'b0;
      trap_tt    <= '0;
      trap_pc    <= '0;
      trap_npc   <= '0;
    end else begin
      trap_taken <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          op_q   <= acc_op;
          data_q <= (acc_op == OP_TRAP) ? acc_vec : ctl.ctl_target;
          state  <= ST_STEP1;
          if (acc_op == OP_TRAP) begin
            trap_taken <= 1'b1;
            trap_tt    <= acc_tt;
            trap_pc    <= pc_cur;
            trap_npc   <= npc_cur;
            // A trap with traps disabled is unrecoverable until reset.
            if (!et) state <= ST_ERROR;
          end
        end
        ST_STEP1: state <= (op_q == OP_SEQ) ? ST_IDLE : ST_STEP2;
        ST_STEP2: state <= ST_IDLE;
        default:  state <= ST_ERROR;
      endcase
    end
  end

  // Strobe decode: each step issues at most one action to the PC pair.
  always_comb begin
    pc_wr   = 1'b0;
    pc_in   = '0;
    npc_wr  = 1'b0;
    npc_in  = '0;
    pcs_inc = 1'b0;
    if (state == ST_STEP1) begin
      case (op_q)
        OP_ANNUL, OP_TRAP: begin npc_wr = 1'b1; npc_in = data_q; end
        OP_LOAD:           begin pc_wr  = 1'b1; pc_in  = data_q; end
        default:           pcs_inc = 1'b1;
      endcase
    end else if (state == ST_STEP2) begin
      case (op_q)
        OP_XFER: begin npc_wr = 1'b1; npc_in = data_q; end
        OP_LOAD: begin npc_wr = 1'b1; npc_in = data_q + 32'd4; end
        OP_ANNUL, OP_SKIP, OP_TRAP: pcs_inc = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized ops
// checked against an architectural model of the PC/nPC effect of each op.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        et;
  logic [19:0] tbr_base;
  logic [31:0] pc_cur, npc_cur;
  logic        pc_wr, npc_wr, pcs_inc, trap_taken, error_mode;
  logic [31:0] pc_in, npc_in, trap_pc, trap_npc;
  logic [7:0]  trap_tt;

  int tests = 0;
  int fails = 0;

  pc_sequencer_if ctl();

  pc_sequencer dut (
    .clk(clk), .rst(rst), .ctl(ctl), .et(et), .tbr_base(tbr_base),
    .pc_cur(pc_cur), .npc_cur(npc_cur),
    .pc_wr(pc_wr), .pc_in(pc_in), .npc_wr(npc_wr), .npc_in(npc_in),
    .pcs_inc(pcs_inc), .trap_taken(trap_taken), .trap_tt(trap_tt),
    .trap_pc(trap_pc), .trap_npc(trap_npc), .error_mode(error_mode)
  );

  always #5 clk = ~clk;

  // PC pair model plus strobe counters.
  logic        ld = 1'b0, cnt_clr = 1'b0;
  logic [31:0] ld_pc = '0, ld_npc = '0;
  int n_inc = 0, n_pcwr = 0, n_npcwr = 0, n_trap = 0;

  always @(posedge clk) begin
    if (ld) begin pc_cur <= ld_pc; npc_cur <= ld_npc; end
    else if (npc_wr) npc_cur <= npc_in;
    else if (pc_wr)  pc_cur  <= pc_in;
    else if (pcs_inc) begin pc_cur <= npc_cur; npc_cur <= npc_cur + 32'd4; end
    n_inc   <= cnt_clr ? 0 : n_inc   + int'(pcs_inc);
    n_pcwr  <= cnt_clr ? 0 : n_pcwr  + int'(pc_wr);
    n_npcwr <= cnt_clr ? 0 : n_npcwr + int'(npc_wr);
    n_trap  <= cnt_clr ? 0 : n_trap  + int'(trap_taken);
  end

  typedef struct {
    logic [31:0] pc, npc;
    logic        err, trap;
    logic [7:0]  tt;
    int          inc, pcwr, npcwr, busy;
  } exp_t;

  // Architectural effect of one op on the PC pair, from the SPARC semantics.
  function automatic exp_t ref_model(input logic [2:0] op, input logic [31:0] tgt,
                                     input logic [7:0] tt, input logic e,
                                     input logic [19:0] tbr,
                                     input logic [31:0] pc, input logic [31:0] npc);
    exp_t r;
    int k;
    logic [31:0] v;
    r.pc = pc; r.npc = npc; r.err = 0; r.trap = 0; r.tt = tt;
    r.inc = 0; r.pcwr = 0; r.npcwr = 0; r.busy = 2;
    k = (op > 5) ? 0 : int'(op);
    if ((k == 1 || k == 2 || k == 5) && tgt[1:0] != 2'b00) begin k = 4; r.tt = 8'h07; end
    v = {tbr, r.tt, 4'h0};
    case (k)
      0: begin r.pc = npc; r.npc = npc + 4; r.inc = 1; r.busy = 1; end
      1: begin r.pc = npc; r.npc = tgt; r.inc = 1; r.npcwr = 1; end
      2: begin r.pc = tgt; r.npc = tgt + 4; r.inc = 1; r.npcwr = 1; end
      3: begin r.pc = npc + 4; r.npc = npc + 8; r.inc = 2; end
      5: begin r.pc = tgt; r.npc = tgt + 4; r.pcwr = 1; r.npcwr = 1; end
      default: begin
        r.trap = 1;
        if (e) begin r.pc = v; r.npc = v + 4; r.inc = 1; r.npcwr = 1; end
        else r.err = 1;
      end
    endcase
    return r;
  endfunction

  task automatic set_state(input logic [31:0] p, input logic [31:0] n);
    @(negedge clk); ld = 1; ld_pc = p; ld_npc = n;
    @(posedge clk); #1; ld = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
  endtask

  // Offer one op, then count cycles until ctl_ready returns (bounded).
  task automatic do_op(input logic [2:0] op, input logic [31:0] tgt,
                       input logic [7:0] tt, output int busy);
    @(negedge clk);
    ctl.ctl_valid = 1; ctl.ctl_op = op; ctl.ctl_target = tgt; ctl.ctl_tt = tt; cnt_clr = 1;
    @(posedge clk); #1;
    ctl.ctl_valid = 0; cnt_clr = 0;
    ctl.ctl_op = 3'($urandom); ctl.ctl_target = $urandom; ctl.ctl_tt = 8'($urandom);
    busy = 0;
    while (ctl.ctl_ready !== 1'b1 && busy < 8) begin @(posedge clk); #1; busy++; end
  endtask

  task automatic test_reset();
    rst = 1; ld = 1; ld_pc = 0; ld_npc = 4;
    ctl.ctl_valid = 0; ctl.ctl_op = 0; ctl.ctl_target = 0; ctl.ctl_tt = 0;
    et = 1; tbr_base = 20'h00040;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0; ld = 0;
    tests++; if (ctl.ctl_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ctl.ctl_ready); end
    tests++; if ({pc_wr, npc_wr, pcs_inc, trap_taken, error_mode} !== 5'b0) begin fails++; $display("FAIL reset_strobes got %b want 00000", {pc_wr, npc_wr, pcs_inc, trap_taken, error_mode}); end
    tests++; if ({pc_in, npc_in} !== 64'h0) begin fails++; $display("FAIL reset_data got %h/%h want 0/0", pc_in, npc_in); end
    tests++; if ({trap_tt, trap_pc, trap_npc} !== 72'h0) begin fails++; $display("FAIL reset_trapregs got %h %h %h want 0", trap_tt, trap_pc, trap_npc); end
  endtask

  task automatic test_seq();
    int busy;
    set_state(32'h0, 32'h4);
    for (int i = 0; i < 3; i++) begin
      do_op(3'd0, 32'h0, 8'h0, busy);
      tests++; if (pc_cur !== 32'(4 * (i + 1)) || npc_cur !== 32'(4 * (i + 2))) begin fails++; $display("FAIL seq_pc%0d got %h/%h want %h/%h", i, pc_cur, npc_cur, 4 * (i + 1), 4 * (i + 2)); end
      tests++; if (n_inc != 1 || busy != 1) begin fails++; $display("FAIL seq_timing%0d got inc=%0d busy=%0d want 1/1", i, n_inc, busy); end
    end
  endtask

  task automatic test_xfer();
    int busy;
    set_state(32'h100, 32'h104);
    do_op(3'd1, 32'h200, 8'h0, busy);
    tests++; if (pc_cur !== 32'h104 || npc_cur !== 32'h200) begin fails++; $display("FAIL xfer_pc got %h/%h want 104/200", pc_cur, npc_cur); end
    tests++; if (n_inc != 1 || n_npcwr != 1 || busy != 2) begin fails++; $display("FAIL xfer_strobes got inc=%0d npcwr=%0d busy=%0d want 1/1/2", n_inc, n_npcwr, busy); end
    set_state(32'h100, 32'h104);
    do_op(3'd2, 32'h200, 8'h0, busy);
    tests++; if (pc_cur !== 32'h200 || npc_cur !== 32'h204) begin fails++; $display("FAIL annul_pc got %h/%h want 200/204", pc_cur, npc_cur); end
  endtask

  task automatic test_skip();
    int busy;
    set_state(32'h100, 32'h104);
    do_op(3'd3, 32'h0, 8'h0, busy);
    tests++; if (pc_cur !== 32'h108 || npc_cur !== 32'h10C) begin fails++; $display("FAIL skip_pc got %h/%h want 108/10C", pc_cur, npc_cur); end
    tests++; if (n_inc != 2 || busy != 2) begin fails++; $display("FAIL skip_strobes got inc=%0d busy=%0d want 2/2", n_inc, busy); end
  endtask

  task automatic test_trap();
    int busy;
    et = 1; tbr_base = 20'h00040;
    set_state(32'h100, 32'h104);
    do_op(3'd4, 32'h0, 8'h05, busy);
    tests++; if (pc_cur !== 32'h40050 || npc_cur !== 32'h40054) begin fails++; $display("FAIL trap_pc got %h/%h want 40050/40054", pc_cur, npc_cur); end
    tests++; if (n_trap != 1) begin fails++; $display("FAIL trap_pulse got %0d want 1", n_trap); end
    tests++; if (trap_tt !== 8'h05 || trap_pc !== 32'h100 || trap_npc !== 32'h104) begin fails++; $display("FAIL trap_regs got %h %h %h want 05 100 104", trap_tt, trap_pc, trap_npc); end
  endtask

  task automatic test_misaligned();
    int busy;
    et = 1; tbr_base = 20'h00040;
    set_state(32'h100, 32'h104);
    do_op(3'd1, 32'h202, 8'h00, busy);
    tests++; if (pc_cur !== 32'h00040070 || npc_cur !== 32'h00040074 || trap_tt !== 8'h07) begin fails++; $display("FAIL misalign_trap got %h/%h tt=%h want 40070/40074 tt=07", pc_cur, npc_cur, trap_tt); end
    et = 0;
    set_state(32'h100, 32'h104);
    do_op(3'd1, 32'h202, 8'h00, busy);
    tests++; if (error_mode !== 1'b1 || ctl.ctl_ready !== 1'b0) begin fails++; $display("FAIL error_enter got err=%b rdy=%b want 1/0", error_mode, ctl.ctl_ready); end
    @(negedge clk); ctl.ctl_valid = 1; ctl.ctl_op = 3'd0;
    repeat (4) @(negedge clk);
    ctl.ctl_valid = 0;
    tests++; if (ctl.ctl_ready !== 1'b0 || (n_inc + n_pcwr + n_npcwr) != 0 || pc_cur !== 32'h100) begin fails++; $display("FAIL error_stuck got rdy=%b strobes=%0d pc=%h want 0/0/100", ctl.ctl_ready, n_inc + n_pcwr + n_npcwr, pc_cur); end
    apply_reset();
    et = 1;
    tests++; if (error_mode !== 1'b0 || ctl.ctl_ready !== 1'b1) begin fails++; $display("FAIL error_exit got err=%b rdy=%b want 0/1", error_mode, ctl.ctl_ready); end
  endtask

  task automatic test_load_wrap();
    int busy;
    set_state(32'h100, 32'h104);
    do_op(3'd5, 32'hFFFFFFFC, 8'h0, busy);
    tests++; if (pc_cur !== 32'hFFFFFFFC || npc_cur !== 32'h0) begin fails++; $display("FAIL load_wrap got %h/%h want FFFFFFFC/00000000", pc_cur, npc_cur); end
    tests++; if (n_pcwr != 1 || n_npcwr != 1 || n_inc != 0) begin fails++; $display("FAIL load_strobes got pcwr=%0d npcwr=%0d inc=%0d want 1/1/0", n_pcwr, n_npcwr, n_inc); end
  endtask

  task automatic test_mid_reset();
    set_state(32'h100, 32'h104);
    @(negedge clk);
    ctl.ctl_valid = 1; ctl.ctl_op = 3'd1; ctl.ctl_target = 32'h200; cnt_clr = 1;
    @(posedge clk); #1;
    ctl.ctl_valid = 0; cnt_clr = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    tests++; if (ctl.ctl_ready !== 1'b1 || {pc_wr, npc_wr, pcs_inc, trap_taken, error_mode} !== 5'b0 || {pc_in, npc_in} !== 64'h0) begin fails++; $display("FAIL midrst_idle got rdy=%b strobes=%b data=%h/%h want 1/00000/0/0", ctl.ctl_ready, {pc_wr, npc_wr, pcs_inc, trap_taken, error_mode}, pc_in, npc_in); end
    repeat (2) @(posedge clk); #1;
    tests++; if (n_npcwr != 0) begin fails++; $display("FAIL midrst_npcwr got %0d want 0", n_npcwr); end
  endtask

  task automatic test_random();
    int busy;
    exp_t r;
    logic [2:0]  op;
    logic [31:0] tgt;
    logic [7:0]  tt;
    logic [7:0]  q_tt = trap_tt;
    logic [31:0] q_pc = trap_pc, q_npc = trap_npc;
    set_state($urandom & 32'hFFFFFFFC, $urandom & 32'hFFFFFFFC);
    for (int i = 0; i < 60; i++) begin
      op  = 3'($urandom_range(0, 7));
      tgt = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFFFFFC);
      if ($urandom_range(0, 9) == 0) tgt = 32'hFFFFFFFC;
      tt  = 8'($urandom);
      et  = ($urandom_range(0, 11) != 0);
      tbr_base = 20'($urandom);
      r = ref_model(op, tgt, tt, et, tbr_base, pc_cur, npc_cur);
      if (r.trap) begin q_tt = r.tt; q_pc = pc_cur; q_npc = npc_cur; end
      do_op(op, tgt, tt, busy);
      if (r.err) begin
        tests++; if (error_mode !== 1'b1 || ctl.ctl_ready !== 1'b0 || (n_inc + n_pcwr + n_npcwr) != 0) begin fails++; $display("FAIL rnd%0d_err got err=%b rdy=%b strobes=%0d want 1/0/0", i, error_mode, ctl.ctl_ready, n_inc + n_pcwr + n_npcwr); end
        apply_reset();
        q_tt = 0; q_pc = 0; q_npc = 0;
      end else begin
        tests++; if (pc_cur !== r.pc || npc_cur !== r.npc) begin fails++; $display("FAIL rnd%0d_pc op=%0d got %h/%h want %h/%h", i, op, pc_cur, npc_cur, r.pc, r.npc); end
        tests++; if (busy != r.busy || n_inc != r.inc || n_pcwr != r.pcwr || n_npcwr != r.npcwr) begin fails++; $display("FAIL rnd%0d_strobes op=%0d got busy=%0d inc=%0d pcwr=%0d npcwr=%0d want %0d/%0d/%0d/%0d", i, op, busy, n_inc, n_pcwr, n_npcwr, r.busy, r.inc, r.pcwr, r.npcwr); end
        tests++; if (n_trap != int'(r.trap) || trap_tt !== q_tt || trap_pc !== q_pc || trap_npc !== q_npc) begin fails++; $display("FAIL rnd%0d_trap got n=%0d %h %h %h want n=%0d %h %h %h", i, n_trap, trap_tt, trap_pc, trap_npc, r.trap, q_tt, q_pc, q_npc); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_xfer();
    test_skip();
    test_trap();
    test_misaligned();
    test_load_wrap();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
